// File: rtl/uv_pipe_sched_pkg.sv
// Shared helpers for the pipelined-datapath scheduler: width math and the assertion macro.
`ifndef UV_PIPE_SCHED_PKG_SV
`define UV_PIPE_SCHED_PKG_SV

// Concurrent check that fires when cond is ever true outside reset.
`define UV_ASSERT_NEVER(clk_s, rst_s, cond, msg) \
   assert property (@(posedge clk_s) disable iff (!(rst_s)) !(cond)) else $error(msg);

package uv_pipe_sched_pkg;

   // Ceiling log2, valid for v >= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(v)) r++;
      return r;
   endfunction

   // Requester ID width, never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

endpackage

`endif

// File: rtl/uv_pipe.sv
// Generic reset-to-zero delay line; STAGE=0 is a straight wire.
module uv_pipe #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned STAGE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   generate
      if (STAGE == 0) begin : g_comb
         assign o_data = i_data;
      end else begin : g_reg
         logic [WIDTH-1:0] r_stage [STAGE];

         // Shift the payload one stage per cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < int'(STAGE); i++) r_stage[i] <= '0;
            end else begin
               r_stage[0] <= i_data;
               for (int i = 1; i < int'(STAGE); i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign o_data = r_stage[STAGE-1];
      end
   endgenerate

endmodule

// File: rtl/uv_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after i_ptr, wrapping.
module uv_rr_arb
   import uv_pipe_sched_pkg::*;
#(
   parameter  int unsigned REQ_NUM = 4,
   localparam int unsigned IDX_W   = id_width(REQ_NUM)
) (
   input  logic [REQ_NUM-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   input  logic               i_en,
   output logic [REQ_NUM-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   // Search ptr, ptr+1, ... mod REQ_NUM; grant is gated by i_en, index/any are not.
   always_comb begin
      int unsigned j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = 0;
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
         j = 32'(i_ptr) + k;
         if (j >= REQ_NUM) j = j - REQ_NUM;
         if (!o_any && i_req[IDX_W'(j)]) begin
            o_any = 1'b1;
            o_idx = IDX_W'(j);
         end
      end
      if (i_en && o_any) o_grant[o_idx] = 1'b1;
   end

endmodule

// File: rtl/uv_pipe_sched.sv
// Shares one fixed-latency pipelined datapath among REQ_NUM requesters with a
// credit-limited, in-order response FIFO.
module uv_pipe_sched
   import uv_pipe_sched_pkg::*;
#(
   parameter  int unsigned REQ_NUM        = 4,
   parameter  int unsigned DATA_WIDTH     = 32,
   parameter  int unsigned PIPE_STAGE     = 2,
   parameter  int unsigned RSP_FIFO_DEPTH = 4,
   localparam int unsigned ID_W           = id_width(REQ_NUM)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [REQ_NUM-1:0]            req_vld,
   output logic [REQ_NUM-1:0]            req_rdy,
   input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
   output logic                          dp_in_vld,
   output logic [DATA_WIDTH-1:0]         dp_in_data,
   input  logic [DATA_WIDTH-1:0]         dp_out_data,
   output logic                          rsp_vld,
   input  logic                          rsp_rdy,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]               rsp_id,
   output logic                          busy
);

   localparam int unsigned AW    = clog2(RSP_FIFO_DEPTH);
   localparam int unsigned CNT_W = AW + 1;
   localparam int unsigned ENT_W = DATA_WIDTH + ID_W;

   logic [ID_W-1:0]  r_ptr;
   logic [CNT_W-1:0] r_outst;
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [ENT_W-1:0] r_mem [RSP_FIFO_DEPTH];

   logic             w_issue_ok;
   logic             w_any;
   logic             w_issue;
   logic [ID_W-1:0]  w_gidx;
   logic [ID_W:0]    w_p_out;
   logic             w_p_vld;
   logic [ID_W-1:0]  w_p_id;
   logic             w_push;
   logic             w_pop;
   logic             w_full;

   // Reset holds off issue so req_rdy/dp_in_vld read zero while rst_n is low.
   assign w_issue_ok = rst_n && (r_outst < CNT_W'(RSP_FIFO_DEPTH));

   uv_rr_arb #(.REQ_NUM(REQ_NUM)) u_arb (
      .i_req   (req_vld),
      .i_ptr   (r_ptr),
      .i_en    (w_issue_ok),
      .o_grant (req_rdy),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   assign w_issue   = w_any & w_issue_ok;
   assign dp_in_vld = w_issue;

   // Select the granted requester's operand.
   always_comb begin
      dp_in_data = '0;
      for (int i = 0; i < int'(REQ_NUM); i++) begin
         if (w_gidx == ID_W'(i)) dp_in_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // {vld,id} travels alongside the external datapath to qualify its result.
   uv_pipe #(.WIDTH(1 + ID_W), .STAGE(PIPE_STAGE)) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data ({w_issue, w_gidx}),
      .o_data (w_p_out)
   );

   assign w_p_vld = w_p_out[ID_W];
   assign w_p_id  = w_p_out[ID_W-1:0];

   assign w_push  = w_p_vld;
   assign rsp_vld = (r_wptr != r_rptr);
   assign w_pop   = rsp_vld & rsp_rdy;
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign {rsp_data, rsp_id} = r_mem[r_rptr[AW-1:0]];
   assign busy    = (r_outst != '0);

   // Round-robin pointer advances past the granted requester on issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_issue) begin
         r_ptr <= (w_gidx == ID_W'(REQ_NUM - 1)) ? '0 : w_gidx + 1'b1;
      end
   end

   // Outstanding-op credit counter: datapath occupancy plus FIFO entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outst <= '0;
      end else begin
         unique case ({w_issue, w_pop})
            2'b10:   r_outst <= r_outst + 1'b1;
            2'b01:   r_outst <= r_outst - 1'b1;
            default: r_outst <= r_outst;
         endcase
      end
   end

   // FIFO pointers with an extra wrap bit for full/empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // FIFO storage; contents are don't-care until the write pointer passes them.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= {dp_out_data, w_p_id};
   end

   `UV_ASSERT_NEVER(clk, rst_n, w_push && w_full, "uv_pipe_sched: response FIFO push while full")

endmodule

// File: tb/tb_uv_pipe_sched.sv
// Randomized self-checking bench for uv_pipe_sched against a queue-based reference model.
module tb_uv_pipe_sched;

   localparam int DEPTH = 4;
   localparam int P     = 2;

   typedef struct {
      logic [31:0] d;
      int          id;
      int          rc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_vld;
   logic [3:0]   req_rdy;
   logic [127:0] req_data;
   logic         dp_in_vld;
   logic [31:0]  dp_in_data;
   logic [31:0]  dp_out_data;
   logic         rsp_vld;
   logic         rsp_rdy;
   logic [31:0]  rsp_data;
   logic [1:0]   rsp_id;
   logic         busy;

   logic [3:0]   z_req_vld;
   logic [3:0]   z_req_rdy;
   logic [127:0] z_req_data;
   logic         z_dp_in_vld;
   logic [31:0]  z_dp_in_data;
   logic [31:0]  z_dp_out_data;
   logic         z_rsp_vld;
   logic         z_rsp_rdy;
   logic [31:0]  z_rsp_data;
   logic [1:0]   z_rsp_id;
   logic         z_busy;

   logic [31:0]  dp_d1, dp_d2;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   m_ptr  = 0;
   int   n_dut_issue = 0;
   exp_t m_q[$];

   logic [3:0]  o_rdy;
   logic        o_rvld;
   logic [31:0] o_rdata;
   logic [1:0]  o_rid;
   logic        o_busy;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External datapath: x+1 with PIPE_STAGE=2 latency.
   always @(posedge clk) begin
      dp_d1 <= dp_in_data + 32'd1;
      dp_d2 <= dp_d1;
   end
   assign dp_out_data   = dp_d2;
   assign z_dp_out_data = z_dp_in_data + 32'd1;

   uv_pipe_sched #(.REQ_NUM(4), .DATA_WIDTH(32), .PIPE_STAGE(P), .RSP_FIFO_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
      .dp_in_vld(dp_in_vld), .dp_in_data(dp_in_data), .dp_out_data(dp_out_data),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
   );

   uv_pipe_sched #(.REQ_NUM(4), .DATA_WIDTH(32), .PIPE_STAGE(0), .RSP_FIFO_DEPTH(DEPTH)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_vld(z_req_vld), .req_rdy(z_req_rdy), .req_data(z_req_data),
      .dp_in_vld(z_dp_in_vld), .dp_in_data(z_dp_in_data), .dp_out_data(z_dp_out_data),
      .rsp_vld(z_rsp_vld), .rsp_rdy(z_rsp_rdy), .rsp_data(z_rsp_data), .rsp_id(z_rsp_id), .busy(z_busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One cycle: drive, compare against the model, then advance the model.
   task automatic step(input logic [3:0] vld, input logic rdy, input bit rnd);
      int          g;
      int          idx;
      bit          e_vld;
      logic [31:0] gd;
      @(negedge clk);
      req_vld = vld;
      rsp_rdy = rdy;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = rnd ? $urandom : 32'h5;
      #1;
      g = -1;
      if (m_q.size() < DEPTH) begin
         for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (g < 0 && vld[idx]) g = idx;
         end
      end
      chk("req_rdy", 32'(req_rdy), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("dp_in_vld", 32'(dp_in_vld), 32'(g >= 0));
      gd = 32'd0;
      if (g >= 0) begin
         gd = req_data[g*32 +: 32];
         chk("dp_in_data", dp_in_data, gd);
      end
      e_vld = (m_q.size() > 0) && (m_q[0].rc <= cyc);
      chk("rsp_vld", 32'(rsp_vld), 32'(e_vld));
      if (e_vld) begin
         chk("rsp_data", rsp_data, m_q[0].d);
         chk("rsp_id", 32'(rsp_id), 32'(m_q[0].id));
      end
      chk("busy", 32'(busy), 32'(m_q.size() != 0));
      o_rdy = req_rdy; o_rvld = rsp_vld; o_rdata = rsp_data; o_rid = rsp_id; o_busy = busy;
      n_dut_issue += int'(dp_in_vld);
      if (e_vld && rdy) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back('{d: gd + 32'd1, id: g, rc: cyc + P + 1});
         m_ptr = (g + 1) % 4;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && m_q.size() != 0; n++) step(4'b0000, 1'b1, 1'b1);
      step(4'b0000, 1'b1, 1'b1);
      chk("drain_busy", 32'(o_busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      rst_n = 1'b0;
      req_vld = 4'hf; rsp_rdy = 1'b1; req_data = '0;
      z_req_vld = '0; z_rsp_rdy = 1'b0; z_req_data = '0;
      #12;
      chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_dp_in_vld", 32'(dp_in_vld), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_vld = '0;

      // Single op from requester 2.
      step(4'b0100, 1'b1, 1'b0);
      chk("single_rdy", 32'(o_rdy), 32'h4);
      step(4'b0000, 1'b1, 1'b1);
      chk("single_early1", 32'(o_rvld), 32'd0);
      step(4'b0000, 1'b1, 1'b1);
      chk("single_early2", 32'(o_rvld), 32'd0);
      step(4'b0000, 1'b1, 1'b1);
      chk("single_vld", 32'(o_rvld), 32'd1);
      chk("single_data", o_rdata, 32'h6);
      chk("single_id", 32'(o_rid), 32'd2);
      drain();

      // Fairness: all valid, sink always ready.
      step(4'b1111, 1'b1, 1'b1);
      prev = $clog2(int'(o_rdy));
      for (int n = 0; n < 8; n++) begin
         step(4'b1111, 1'b1, 1'b1);
         chk("fair_seq", 32'($clog2(int'(o_rdy))), 32'((prev + 1) % 4));
         prev = $clog2(int'(o_rdy));
      end
      drain();

      // Backpressure: sink stalled, credits cap issue at DEPTH.
      n_dut_issue = 0;
      for (int n = 0; n < 8; n++) step(4'b1111, 1'b0, 1'b1);
      chk("bp_issue_cnt", 32'(n_dut_issue), 32'(DEPTH));
      chk("bp_rdy", 32'(o_rdy), 32'd0);
      chk("bp_busy", 32'(o_busy), 32'd1);
      step(4'b1111, 1'b1, 1'b1);
      chk("bp_pop_no_issue", 32'(o_rdy), 32'd0);
      step(4'b1111, 1'b0, 1'b1);
      chk("bp_one_issue", 32'($countones(o_rdy)), 32'd1);
      step(4'b1111, 1'b0, 1'b1);
      chk("bp_stall_again", 32'(o_rdy), 32'd0);
      drain();

      // Reset mid-flight with three ops outstanding and ptr left at 3.
      step(4'b0100, 1'b0, 1'b1);
      step(4'b1000, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b1);
      @(negedge clk);
      req_vld = 4'b1111;
      rst_n = 1'b0;
      #1;
      chk("mrst_rsp_vld", 32'(rsp_vld), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_req_rdy", 32'(req_rdy), 32'd0);
      chk("mrst_dp_in_vld", 32'(dp_in_vld), 32'd0);
      m_q.delete();
      m_ptr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      req_vld = '0;
      step(4'b1100, 1'b1, 1'b1);
      chk("mrst_first_grant", 32'(o_rdy), 32'h4);
      drain();

      // Random traffic with random sink backpressure.
      for (int n = 0; n < 300; n++)
         step(4'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0), 1'b1);
      drain();

      // Combinational datapath instance: issue at t, response at t+1.
      @(negedge clk);
      z_req_vld = 4'b1000;
      z_req_data[96 +: 32] = 32'h33;
      z_rsp_rdy = 1'b0;
      #1;
      chk("p0_req_rdy", 32'(z_req_rdy), 32'h8);
      chk("p0_dp_in_vld", 32'(z_dp_in_vld), 32'd1);
      chk("p0_no_bypass", 32'(z_rsp_vld), 32'd0);
      @(negedge clk);
      z_req_vld = '0;
      #1;
      chk("p0_rsp_vld", 32'(z_rsp_vld), 32'd1);
      chk("p0_rsp_data", z_rsp_data, 32'h34);
      chk("p0_rsp_id", 32'(z_rsp_id), 32'd3);
      z_rsp_rdy = 1'b1;
      @(negedge clk);
      #1;
      chk("p0_empty", 32'(z_rsp_vld), 32'd0);
      chk("p0_idle", 32'(z_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
